// File: rtl/riscv_biu_arb.sv
// Two-master BIU arbiter in front of the AHB4 bridge.
// Port 0 = data-cache BIU, port 1 = instruction-fetch BIU.
module riscv_biu_arb #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
) (
  input  logic            HRESETn,
  input  logic            HCLK,

  input  logic            biu0_stb_i,
  output logic            biu0_stb_ack_o,
  output logic            biu0_d_ack_o,
  input  logic [PLEN-1:0] biu0_adri_i,
  output logic [PLEN-1:0] biu0_adro_o,
  input  logic [2:0]      biu0_size_i,
  input  logic [2:0]      biu0_type_i,
  input  logic [2:0]      biu0_prot_i,
  input  logic            biu0_lock_i,
  input  logic            biu0_we_i,
  input  logic [XLEN-1:0] biu0_d_i,
  output logic [XLEN-1:0] biu0_q_o,
  output logic            biu0_ack_o,
  output logic            biu0_err_o,

  input  logic            biu1_stb_i,
  output logic            biu1_stb_ack_o,
  output logic            biu1_d_ack_o,
  input  logic [PLEN-1:0] biu1_adri_i,
  output logic [PLEN-1:0] biu1_adro_o,
  input  logic [2:0]      biu1_size_i,
  input  logic [2:0]      biu1_type_i,
  input  logic [2:0]      biu1_prot_i,
  input  logic            biu1_lock_i,
  input  logic            biu1_we_i,
  input  logic [XLEN-1:0] biu1_d_i,
  output logic [XLEN-1:0] biu1_q_o,
  output logic            biu1_ack_o,
  output logic            biu1_err_o,

  output logic            biu_stb_o,
  input  logic            biu_stb_ack_i,
  input  logic            biu_d_ack_i,
  output logic [PLEN-1:0] biu_adri_o,
  input  logic [PLEN-1:0] biu_adro_i,
  output logic [2:0]      biu_size_o,
  output logic [2:0]      biu_type_o,
  output logic [2:0]      biu_prot_o,
  output logic            biu_lock_o,
  output logic            biu_we_o,
  output logic [XLEN-1:0] biu_d_o,
  input  logic [XLEN-1:0] biu_q_i,
  input  logic            biu_ack_i,
  input  logic            biu_err_i
);

  // GAP is the single dead idle cycle after every burst end
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  state_t     state;
  state_t     nxt_state;
  logic       owner;
  logic       nxt_owner;
  logic       rr_last;
  logic       nxt_rr_last;
  logic       lock_hold;
  logic       nxt_lock_hold;
  logic [3:0] beat_cnt;
  logic [3:0] nxt_beat_cnt;

  logic [1:0] stb;
  logic [1:0] lock;
  logic       sel;
  logic       cur;
  logic       req;
  logic [2:0] cur_type;

  assign stb  = {biu1_stb_i, biu0_stb_i};
  assign lock = {biu1_lock_i, biu0_lock_i};

  // remaining beats after the first one, by burst type
  function automatic logic [3:0] type2cnt(input logic [2:0] t);
    logic [3:0] c;
    unique case (t)
      3'd0, 3'd1: c = 4'd0;
      3'd2, 3'd3: c = 4'd3;
      3'd4, 3'd5: c = 4'd7;
      default:    c = 4'd15;
    endcase
    return c;
  endfunction

  // idle arbitration: lock first, then single requester, then round-robin
  always_comb begin
    sel = owner;
    if (lock_hold)
      sel = owner;
    else if (stb == 2'b11)
      sel = ~rr_last;
    else if (stb[1])
      sel = 1'b1;
    else if (stb[0])
      sel = 1'b0;
  end

  assign cur      = (state == IDLE) ? sel : owner;
  assign req      = HRESETn & (state == IDLE) & stb[sel];
  assign cur_type = cur ? biu1_type_i : biu0_type_i;

  // state register and arbitration bookkeeping
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      owner     <= 1'b0;
      rr_last   <= 1'b1;
      lock_hold <= 1'b0;
      beat_cnt  <= 4'd0;
    end else begin
      state     <= nxt_state;
      owner     <= nxt_owner;
      rr_last   <= nxt_rr_last;
      lock_hold <= nxt_lock_hold;
      beat_cnt  <= nxt_beat_cnt;
    end
  end

  // next-state: grant, beat counting, error abort, lock release
  always_comb begin
    nxt_state     = state;
    nxt_owner     = owner;
    nxt_rr_last   = rr_last;
    nxt_lock_hold = lock_hold;
    nxt_beat_cnt  = beat_cnt;
    unique case (state)
      IDLE: begin
        if (lock_hold && !lock[owner])
          nxt_lock_hold = 1'b0;
        if (req && biu_stb_ack_i) begin
          nxt_state    = BUSY;
          nxt_owner    = sel;
          nxt_rr_last  = sel;
          nxt_beat_cnt = type2cnt(cur_type);
        end
      end
      BUSY: begin
        if (biu_err_i) begin
          nxt_state     = GAP;
          nxt_beat_cnt  = 4'd0;
          nxt_lock_hold = 1'b0;
        end else if (biu_ack_i) begin
          if (beat_cnt == 4'd0) begin
            nxt_state     = GAP;
            nxt_lock_hold = lock[owner];
          end else begin
            nxt_beat_cnt = beat_cnt - 4'd1;
          end
        end
      end
      GAP: begin
        nxt_state = IDLE;
        if (lock_hold && !lock[owner])
          nxt_lock_hold = 1'b0;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // outputs: request mux to bridge, responses to owner only
  always_comb begin
    biu_stb_o      = req;
    biu_adri_o     = cur ? biu1_adri_i : biu0_adri_i;
    biu_size_o     = cur ? biu1_size_i : biu0_size_i;
    biu_type_o     = cur_type;
    biu_prot_o     = cur ? biu1_prot_i : biu0_prot_i;
    biu_lock_o     = cur ? biu1_lock_i : biu0_lock_i;
    biu_we_o       = cur ? biu1_we_i   : biu0_we_i;
    biu_d_o        = cur ? biu1_d_i    : biu0_d_i;

    biu0_stb_ack_o = req & ~sel & biu_stb_ack_i;
    biu1_stb_ack_o = req &  sel & biu_stb_ack_i;

    biu0_d_ack_o   = 1'b0;
    biu0_ack_o     = 1'b0;
    biu0_err_o     = 1'b0;
    biu0_q_o       = '0;
    biu0_adro_o    = '0;
    biu1_d_ack_o   = 1'b0;
    biu1_ack_o     = 1'b0;
    biu1_err_o     = 1'b0;
    biu1_q_o       = '0;
    biu1_adro_o    = '0;

    if (state == BUSY) begin
      if (owner) begin
        biu1_d_ack_o = biu_d_ack_i;
        biu1_ack_o   = biu_ack_i;
        biu1_err_o   = biu_err_i;
        biu1_q_o     = biu_q_i;
        biu1_adro_o  = biu_adro_i;
      end else begin
        biu0_d_ack_o = biu_d_ack_i;
        biu0_ack_o   = biu_ack_i;
        biu0_err_o   = biu_err_i;
        biu0_q_o     = biu_q_i;
        biu0_adro_o  = biu_adro_i;
      end
    end
  end

endmodule

// File: tb/tb_riscv_biu_arb.sv
// Directed bench for riscv_biu_arb.
// Vector table of bursts plus hand-written arbitration sequences.
module tb_riscv_biu_arb;

  logic        HRESETn;
  logic        HCLK;

  logic        stb0, stb1, lock0, lock1, we0, we1;
  logic [2:0]  size0, size1, typ0, typ1, prot0, prot1;
  logic [63:0] adr0, adr1, wd0, wd1;

  logic        s0ack, s1ack, d0ack, d1ack;
  logic        a0, a1, e0, e1;
  logic [63:0] q0, q1, adro0, adro1;

  logic        biu_stb_o, biu_lock_o, biu_we_o;
  logic [63:0] biu_adri_o, biu_d_o;
  logic [2:0]  biu_size_o, biu_type_o, biu_prot_o;

  logic        b_sack, b_dack, b_ack, b_err;
  logic [63:0] b_adro, b_q;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        port;
    logic [2:0]  typ;
    logic [63:0] adr;
    logic        we;
    int          nbeats;
    int          errb;
  } vec_t;

  vec_t tbl[7];

  riscv_biu_arb #(.XLEN(64), .PLEN(64)) dut (
    .HRESETn        (HRESETn),
    .HCLK           (HCLK),
    .biu0_stb_i     (stb0),
    .biu0_stb_ack_o (s0ack),
    .biu0_d_ack_o   (d0ack),
    .biu0_adri_i    (adr0),
    .biu0_adro_o    (adro0),
    .biu0_size_i    (size0),
    .biu0_type_i    (typ0),
    .biu0_prot_i    (prot0),
    .biu0_lock_i    (lock0),
    .biu0_we_i      (we0),
    .biu0_d_i       (wd0),
    .biu0_q_o       (q0),
    .biu0_ack_o     (a0),
    .biu0_err_o     (e0),
    .biu1_stb_i     (stb1),
    .biu1_stb_ack_o (s1ack),
    .biu1_d_ack_o   (d1ack),
    .biu1_adri_i    (adr1),
    .biu1_adro_o    (adro1),
    .biu1_size_i    (size1),
    .biu1_type_i    (typ1),
    .biu1_prot_i    (prot1),
    .biu1_lock_i    (lock1),
    .biu1_we_i      (we1),
    .biu1_d_i       (wd1),
    .biu1_q_o       (q1),
    .biu1_ack_o     (a1),
    .biu1_err_o     (e1),
    .biu_stb_o      (biu_stb_o),
    .biu_stb_ack_i  (b_sack),
    .biu_d_ack_i    (b_dack),
    .biu_adri_o     (biu_adri_o),
    .biu_adro_i     (b_adro),
    .biu_size_o     (biu_size_o),
    .biu_type_o     (biu_type_o),
    .biu_prot_o     (biu_prot_o),
    .biu_lock_o     (biu_lock_o),
    .biu_we_o       (biu_we_o),
    .biu_d_o        (biu_d_o),
    .biu_q_i        (b_q),
    .biu_ack_i      (b_ack),
    .biu_err_i      (b_err)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic logic sack_of(input logic p);
    return p ? s1ack : s0ack;
  endfunction
  function automatic logic ack_of(input logic p);
    return p ? a1 : a0;
  endfunction
  function automatic logic err_of(input logic p);
    return p ? e1 : e0;
  endfunction
  function automatic logic dack_of(input logic p);
    return p ? d1ack : d0ack;
  endfunction
  function automatic logic [63:0] q_of(input logic p);
    return p ? q1 : q0;
  endfunction
  function automatic logic [63:0] adro_of(input logic p);
    return p ? adro1 : adro0;
  endfunction

  // per-port request fields; size/prot/data derived from port and address
  task automatic set_req(input logic p, input logic on,
                         input logic [2:0] t, input logic [63:0] a,
                         input logic w);
    if (p) begin
      stb1 = on; typ1 = t; adr1 = a; we1 = w;
      size1 = 3'd3; prot1 = 3'd4; wd1 = a ^ 64'hFFFF;
    end else begin
      stb0 = on; typ0 = t; adr0 = a; we0 = w;
      size0 = 3'd2; prot0 = 3'd1; wd0 = a ^ 64'hFFFF;
    end
  endtask

  task automatic zero_inputs;
    set_req(1'b0, 1'b0, 3'd0, 64'h0, 1'b0);
    set_req(1'b1, 1'b0, 3'd0, 64'h0, 1'b0);
    lock0 = 1'b0; lock1 = 1'b0;
    b_sack = 1'b0; b_dack = 1'b0; b_ack = 1'b0; b_err = 1'b0;
    b_adro = '0; b_q = '0;
  endtask

  task automatic do_reset;
    HRESETn = 1'b0;
    zero_inputs();
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  // one burst: grant, beats with routed responses, stray ack after end
  task automatic xfer(input vec_t v);
    logic hit;
    logic p;
    p = v.port;
    hit = 1'b0;
    set_req(p, 1'b1, v.typ, v.adr, v.we);
    b_sack = 1'b1;
    for (int w = 0; w < 8; w++) begin
      #1;
      if (sack_of(p)) begin
        hit = 1'b1;
        break;
      end
      @(negedge HCLK);
    end
    chk("grant", 64'(hit), 64'd1);
    if (hit) begin
      chk("adri", biu_adri_o, v.adr);
      chk("type", 64'(biu_type_o), 64'(v.typ));
      chk("we", 64'(biu_we_o), 64'(v.we));
      chk("size", 64'(biu_size_o), p ? 64'd3 : 64'd2);
      chk("prot", 64'(biu_prot_o), p ? 64'd4 : 64'd1);
      chk("lock", 64'(biu_lock_o), 64'd0);
      chk("d", biu_d_o, v.adr ^ 64'hFFFF);
      chk("sack_other", 64'(sack_of(~p)), 64'd0);
      @(negedge HCLK);
      set_req(p, 1'b0, v.typ, v.adr, v.we);
      b_sack = 1'b0;
      for (int b = 0; b < v.nbeats; b++) begin
        b_ack  = 1'b1;
        b_err  = (b == v.errb);
        b_dack = 1'b1;
        b_q    = v.adr ^ 64'(b);
        b_adro = v.adr + 64'(8 * b);
        #1;
        if (b == v.errb)
          chk("err", 64'(err_of(p)), 64'd1);
        else
          chk("ack", 64'(ack_of(p)), 64'd1);
        chk("dack", 64'(dack_of(p)), 64'd1);
        chk("q", q_of(p), v.adr ^ 64'(b));
        chk("adro", adro_of(p), v.adr + 64'(8 * b));
        chk("other_resp",
            64'({ack_of(~p), err_of(~p), dack_of(~p)}), 64'd0);
        @(negedge HCLK);
      end
      b_err  = 1'b0;
      b_dack = 1'b0;
      b_ack  = 1'b1;
      #1;
      chk("stray_after_end", 64'({a1, a0, e1, e0}), 64'd0);
      @(negedge HCLK);
      b_ack = 1'b0;
    end
  endtask

  logic hit;

  initial begin
    tbl[0] = '{1'b0, 3'd0, 64'h1000, 1'b0, 1, -1};
    tbl[1] = '{1'b1, 3'd2, 64'h2008, 1'b0, 4, -1};
    tbl[2] = '{1'b0, 3'd5, 64'h3000, 1'b0, 4, 3};
    tbl[3] = '{1'b1, 3'd1, 64'h4000, 1'b1, 1, -1};
    tbl[4] = '{1'b0, 3'd3, 64'h5000, 1'b1, 4, -1};
    tbl[5] = '{1'b1, 3'd4, 64'h6000, 1'b0, 8, -1};
    tbl[6] = '{1'b0, 3'd7, 64'h7000, 1'b0, 16, -1};

    HRESETn = 1'b0;
    zero_inputs();
    @(negedge HCLK);
    set_req(1'b0, 1'b1, 3'd0, 64'h1000, 1'b0);
    b_sack = 1'b1;
    #1;
    chk("rst_stb_o", 64'(biu_stb_o), 64'd0);
    chk("rst_sack0", 64'(s0ack), 64'd0);
    @(negedge HCLK);
    zero_inputs();
    HRESETn = 1'b1;

    b_ack = 1'b1; b_err = 1'b1; b_dack = 1'b1;
    #1;
    chk("idle_stray",
        64'({a0, a1, e0, e1, d0ack, d1ack, s0ack, s1ack, biu_stb_o}),
        64'd0);
    @(negedge HCLK);
    b_ack = 1'b0; b_err = 1'b0; b_dack = 1'b0;

    for (int i = 0; i < 7; i++)
      xfer(tbl[i]);

    // round-robin from reset: 0,1,0,1,0,1
    do_reset();
    set_req(1'b0, 1'b1, 3'd0, 64'hA000, 1'b0);
    set_req(1'b1, 1'b1, 3'd0, 64'hB000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      b_sack = 1'b1;
      #1;
      chk("rr_sack", 64'({s1ack, s0ack}),
          (i % 2 == 1) ? 64'd2 : 64'd1);
      chk("rr_adri", biu_adri_o,
          (i % 2 == 1) ? 64'hB000 : 64'hA000);
      @(negedge HCLK);
      b_sack = 1'b0;
      b_ack  = 1'b1;
      #1;
      chk("rr_ack", 64'({a1, a0}), (i % 2 == 1) ? 64'd2 : 64'd1);
      @(negedge HCLK);
      b_ack = 1'b0;
      #1;
      chk("rr_gap_stb", 64'(biu_stb_o), 64'd0);
      @(negedge HCLK);
    end
    zero_inputs();

    // WRAP4 on port 1, port 0 raised mid-burst waits for dead cycle
    do_reset();
    set_req(1'b1, 1'b1, 3'd2, 64'h2008, 1'b0);
    b_sack = 1'b1;
    #1;
    chk("w4_sack1", 64'(s1ack), 64'd1);
    @(negedge HCLK);
    set_req(1'b1, 1'b0, 3'd2, 64'h2008, 1'b0);
    set_req(1'b0, 1'b1, 3'd0, 64'h1000, 1'b0);
    for (int b = 0; b < 4; b++) begin
      b_ack = 1'b1;
      #1;
      chk("w4_ack1", 64'(a1), 64'd1);
      chk("w4_hold0", 64'({s0ack, biu_stb_o, a0}), 64'd0);
      @(negedge HCLK);
    end
    b_ack = 1'b0;
    #1;
    chk("w4_gap", 64'({s0ack, biu_stb_o}), 64'd0);
    @(negedge HCLK);
    #1;
    chk("w4_sack0", 64'(s0ack), 64'd1);
    @(negedge HCLK);
    set_req(1'b0, 1'b0, 3'd0, 64'h1000, 1'b0);
    b_sack = 1'b0;
    b_ack  = 1'b1;
    #1;
    chk("w4_ack0", 64'({a1, a0}), 64'd1);
    @(negedge HCLK);
    b_ack = 1'b0;
    @(negedge HCLK);

    // INCR8 on port 0 aborted by error on beat 3, port 1 pending
    do_reset();
    set_req(1'b0, 1'b1, 3'd5, 64'h3000, 1'b0);
    b_sack = 1'b1;
    #1;
    chk("er_sack0", 64'(s0ack), 64'd1);
    @(negedge HCLK);
    set_req(1'b0, 1'b0, 3'd5, 64'h3000, 1'b0);
    set_req(1'b1, 1'b1, 3'd0, 64'h4000, 1'b0);
    for (int b = 0; b < 3; b++) begin
      b_ack = 1'b1;
      #1;
      chk("er_ack0", 64'(a0), 64'd1);
      chk("er_nosack1", 64'(s1ack), 64'd0);
      @(negedge HCLK);
    end
    b_ack = 1'b0;
    b_err = 1'b1;
    #1;
    chk("er_err0", 64'({e1, e0}), 64'd1);
    @(negedge HCLK);
    b_err = 1'b0;
    b_ack = 1'b1;
    hit = 1'b0;
    for (int w = 0; w < 2; w++) begin
      #1;
      chk("er_noack0", 64'(a0), 64'd0);
      if (s1ack) begin
        hit = 1'b1;
        break;
      end
      @(negedge HCLK);
    end
    chk("er_sack1_2cyc", 64'(hit), 64'd1);
    @(negedge HCLK);
    set_req(1'b1, 1'b0, 3'd0, 64'h4000, 1'b0);
    b_sack = 1'b0;
    b_ack  = 1'b1;
    #1;
    chk("er_ack1", 64'({a1, a0}), 64'd2);
    @(negedge HCLK);
    b_ack = 1'b0;
    @(negedge HCLK);

    // locked port 1 keeps the bus for two writes
    do_reset();
    lock1 = 1'b1;
    set_req(1'b1, 1'b1, 3'd0, 64'h8000, 1'b1);
    b_sack = 1'b1;
    #1;
    chk("lk_sack1a", 64'(s1ack), 64'd1);
    @(negedge HCLK);
    set_req(1'b0, 1'b1, 3'd0, 64'h9000, 1'b0);
    b_ack = 1'b1;
    #1;
    chk("lk_ack1a", 64'(a1), 64'd1);
    @(negedge HCLK);
    b_ack = 1'b0;
    #1;
    chk("lk_gap", 64'(s0ack), 64'd0);
    @(negedge HCLK);
    #1;
    chk("lk_sack1b", 64'({s1ack, s0ack}), 64'd2);
    @(negedge HCLK);
    set_req(1'b1, 1'b0, 3'd0, 64'h8000, 1'b1);
    b_ack = 1'b1;
    #1;
    chk("lk_ack1b", 64'(a1), 64'd1);
    @(negedge HCLK);
    b_ack = 1'b0;
    @(negedge HCLK);
    #1;
    chk("lk_held", 64'(s0ack), 64'd0);
    @(negedge HCLK);
    lock1 = 1'b0;
    hit = 1'b0;
    for (int w = 0; w < 3; w++) begin
      #1;
      if (s0ack) begin
        hit = 1'b1;
        break;
      end
      @(negedge HCLK);
    end
    chk("lk_sack0", 64'(hit), 64'd1);
    @(negedge HCLK);
    zero_inputs();
    b_ack = 1'b1;
    #1;
    chk("lk_ack0", 64'({a1, a0}), 64'd1);
    @(negedge HCLK);
    b_ack = 1'b0;
    @(negedge HCLK);

    // reset asserted during beat 5 of an INCR16
    do_reset();
    set_req(1'b0, 1'b1, 3'd7, 64'h7000, 1'b0);
    b_sack = 1'b1;
    #1;
    chk("rs_sack0", 64'(s0ack), 64'd1);
    @(negedge HCLK);
    set_req(1'b0, 1'b0, 3'd7, 64'h7000, 1'b0);
    b_sack = 1'b0;
    for (int b = 0; b < 5; b++) begin
      b_ack = 1'b1;
      b_dack = 1'b1;
      #1;
      chk("rs_ack0", 64'(a0), 64'd1);
      if (b < 4)
        @(negedge HCLK);
    end
    HRESETn = 1'b0;
    set_req(1'b0, 1'b1, 3'd0, 64'h7000, 1'b0);
    b_sack = 1'b1;
    #1;
    chk("rs_clear",
        64'({a0, a1, e0, e1, d0ack, d1ack, s0ack, s1ack, biu_stb_o}),
        64'd0);
    @(negedge HCLK);
    zero_inputs();
    @(negedge HCLK);
    HRESETn = 1'b1;
    xfer(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
